// File: rtl/uarttx_fifo.sv
// uarttx_fifo: parametrised UART transmitter with a small write FIFO; frames go out back-to-back.
// Optional BREAK generation (tx_break input, BREAK state) is enabled by defining UARTTX_BREAK_EN.
`default_nettype none

module uarttx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          tx_load,
  input  logic [DATA_BITS-1:0]          tx_data,
`ifdef UARTTX_BREAK_EN
  input  logic                          tx_break,
`endif
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  localparam int STOP_CYC = STOP_BITS * CLK_DIV;
  localparam int DW       = $clog2(STOP_CYC);
  localparam int BW       = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
`ifdef UARTTX_BREAK_EN
    , S_BREAK = 3'd5
`endif
  } state_t;

  state_t                 r_state, w_state_n;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [LW-1:0]          r_level, w_level_n;
  logic                   r_ready, r_busy, r_tx, w_tx_n;
  logic [DW-1:0]          r_div, w_div_n;
  logic [BW-1:0]          r_bit, w_bit_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic                   r_par, w_par_n;
  logic                   w_push, w_pop, w_fifo_ne;
  logic                   w_div_last, w_stop_last;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_head_par;

  assign w_push      = tx_load && r_ready;
  assign w_fifo_ne   = (r_level != '0);
  assign w_head      = r_mem[r_rptr];
  // Parity bit chosen so data+parity has odd (mode 1) or even (mode 2) weight
  assign w_head_par  = (PARITY == 1) ? ~(^w_head) : (^w_head);
  assign w_div_last  = (r_div == DW'(CLK_DIV - 1));
  assign w_stop_last = (r_div == DW'(STOP_CYC - 1));
  assign w_level_n   = r_level + LW'(w_push) - LW'(w_pop);

  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
`ifdef UARTTX_BREAK_EN
        if (tx_break) begin
          w_state_n = S_BREAK;
          w_tx_n    = 1'b0;
        end else
`endif
        if (w_fifo_ne) w_pop = 1'b1;
      end
      S_START: begin
        if (w_div_last) begin
          w_state_n = S_DATA;
          w_div_n   = '0;
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      S_DATA: begin
        if (w_div_last) begin
          w_div_n = '0;
          if (r_bit == BW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              w_state_n = S_PAR;
              w_tx_n    = r_par;
            end else begin
              w_state_n = S_STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_bit_n   = r_bit + BW'(1);
            w_shift_n = r_shift >> 1;
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      S_PAR: begin
        if (w_div_last) begin
          w_state_n = S_STOP;
          w_div_n   = '0;
          w_tx_n    = 1'b1;
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      S_STOP: begin
        if (w_stop_last) begin
          w_div_n = '0;
`ifdef UARTTX_BREAK_EN
          if (tx_break) begin
            w_state_n = S_BREAK;
            w_tx_n    = 1'b0;
          end else
`endif
          if (w_fifo_ne) begin
            w_pop = 1'b1;
          end else begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
`ifdef UARTTX_BREAK_EN
      S_BREAK: begin
        w_tx_n = 1'b0;
        // The guard interval reuses the STOP timing before the next START
        if (!tx_break) begin
          w_state_n = S_STOP;
          w_div_n   = '0;
          w_tx_n    = 1'b1;
        end
      end
`endif
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
    if (w_pop) begin
      w_state_n = S_START;
      w_shift_n = w_head;
      w_par_n   = w_head_par;
      w_div_n   = '0;
      w_tx_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_level <= w_level_n;
      r_ready <= (w_level_n != LW'(FIFO_DEPTH));
      r_busy  <= (w_state_n != S_IDLE) || (w_level_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  assign tx_ready   = r_ready;
  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_level = r_level;

endmodule

`default_nettype wire

// File: doc/uarttx_fifo.md
Name: uarttx_fifo

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Adds configurable data width, parity, stop bits and baud divisor, plus a small write FIFO so software or a CPU peripheral bus can queue several characters. Frames go out back-to-back with no idle gap between them. The block keeps the load/ready/tx handshake of the existing transmitter interface.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
CLK_DIV, 16, clk cycles per serial bit, >= 2
STOP_BITS, 1, stop bits per frame, 1 or 2
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
FIFO_DEPTH, 4, FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock, all logic on posedge
nrst  in  1  asynchronous active-low reset
tx_load  in  1  push request, qualified by tx_ready
tx_data  in  DATA_BITS  character to push, sampled only on an accepted push
tx_ready  out  1  FIFO not full
tx  out  1  serial output, idle high
tx_busy  out  1  high while the FSM is not in IDLE or the FIFO is non-empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - tx=1, tx_ready=1, tx_busy=0, fifo_level=0.
  - FSM goes to IDLE; bit counter, divider and pointers are 0; FIFO contents are discarded.
- Push:
  - A push occurs when tx_load && tx_ready at a posedge.
  - tx_load while tx_ready=0 is ignored: no data is written and no state changes.
- Outputs tx_ready, tx_busy, fifo_level and tx are all registered.
  - fifo_level and tx_ready reflect that cycle's push and pop after the edge.
- Simultaneous push and pop: the level is unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if fifo_level != 0, pop the head into the shift register, go to START and drive tx<=0.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, each held CLK_DIV cycles. Then go to PAR if PARITY != 0, else STOP.
  - PAR: odd mode makes total ones (data + parity) odd; even mode makes them even. Held CLK_DIV cycles.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Latency: a push accepted at edge N drives tx low after edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLK_DIV cycles, exact.
- Effective capacity is FIFO_DEPTH + 1 characters: FIFO_DEPTH in the FIFO plus one in the shifter.
- Reset mid-frame: tx goes high immediately without waiting for a clock edge. The partial frame is abandoned and not resumed after reset release.

Optional Feature:
UARTTX_BREAK_EN:
- When defined:
  - Adds input tx_break (1 bit) and a BREAK state.
  - With tx_break high, the current frame completes, then tx is held low while tx_break remains high. The FIFO is not popped during this time; pushes are still accepted.
  - On tx_break deassertion, tx is driven high for a guard of STOP_BITS*CLK_DIV cycles before the next START.
  - tx_busy=1 while in BREAK.
- When undefined: the port and the BREAK state are absent.

Test Plan:
- Defaults, push 0x55 -> after the next edge tx=0 for 16 cycles, then data bits 1,0,1,0,1,0,1,0 (16 cycles each), then stop high; total 160 cycles; tx_busy falls after the last stop cycle; fifo_level returns to 0.
- Defaults, tx_load held for 7 consecutive cycles with 0x01..0x07 -> 0x01..0x05 accepted, tx_ready=0 once the FIFO is full, later pushes dropped; 5 frames back-to-back with no idle cycle between stop and start (800 cycles); 0x06 and 0x07 never transmitted.
- DATA_BITS=7, PARITY=2, push 0x07 -> parity bit 1. Same with PARITY=1 -> parity bit 0. Frame length 10*CLK_DIV.
- STOP_BITS=2, CLK_DIV=4, two queued bytes -> stop high for exactly 8 cycles, next start bit on the following cycle.
- Reset mid-frame: push 0xA5 and 0x3C, assert nrst during bit 3 of the first frame -> tx=1 without a clock edge, fifo_level=0, tx_ready=1; after release, tx stays high and 0x3C is never sent.
- With UARTTX_BREAK_EN defined: raise tx_break during a frame -> the frame completes, tx is held low while tx_break=1; lower tx_break -> tx high for a STOP_BITS*CLK_DIV guard, then the queued frame starts.
